tim_pwm: RTL and testbench
==========================

TIM_PWM -- requirements
Module: tim_pwm

Interface
REQ-001 Parameter WIDTH, default 16, counter/compare width in bits.
REQ-002 Parameter PSC_W, default 16, prescaler width in bits.
REQ-003 Parameter CH, default 4, number of PWM compare channels.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  run enable; level-sensitive.
REQ-007 one_shot  input  1  1 = stop after first counter wrap.
REQ-008 psc  input  PSC_W  prescaler; counter advances once per psc+1 clk cycles.
REQ-009 arr  input  WIDTH  auto-reload; period = arr+1 ticks.
REQ-010 ccr  input  CH x WIDTH  per-channel compare values.
REQ-011 cnt  output  WIDTH  current counter value.
REQ-012 pwm  output  CH  per-channel PWM outputs.
REQ-013 upd  output  1  one-cycle pulse on each counter wrap.
REQ-014 busy  output  1  high while in RUN.

Function
REQ-015 FSM states IDLE, RUN, DONE; registered state.
REQ-016 IDLE->RUN when en=1; on that edge psc_cnt<=0, cnt<=0, shadow arr/ccr loaded.
REQ-017 Any state ->IDLE on the edge where en=0; cnt<=0, psc_cnt<=0, pwm<=0.
REQ-018 Prescaler: tick asserted in RUN when psc_cnt>=psc, then psc_cnt<=0; else psc_cnt<=psc_cnt+1; psc=0 gives tick every cycle.
REQ-019 psc change mid-run takes effect immediately; psc_cnt above new psc produces tick next cycle (>= rule), no wrap-around of psc_cnt.
REQ-020 On tick: cnt==arr_act -> cnt<=0 and upd<=1 for exactly one cycle; else cnt<=cnt+1; arithmetic modulo 2^WIDTH never reached.
REQ-021 arr_act=0: cnt stays 0, upd pulses on every tick.
REQ-022 pwm[i] registered, equals (next cnt < ccr_act[i]) so pwm[i]==(cnt<ccr_act[i]) every cycle in RUN; 0 in IDLE and DONE.
REQ-023 ccr_act[i]=0 -> pwm[i] constant 0; ccr_act[i]>arr_act -> pwm[i] constant 1.
REQ-024 Wrap with one_shot=1 -> DONE on the same edge (upd still pulses); DONE holds cnt=0, busy=0 until en=0.
REQ-025 busy=1 exactly when state==RUN.

Reset
REQ-026 rst=1 forces state=IDLE, cnt=0, psc_cnt=0, pwm=0, upd=0, busy=0, shadows=0, independent of clk.
REQ-027 Reset asserted mid-period aborts immediately; after release the block waits in IDLE for en=1 (en already high -> RUN on first edge).

Configuration
REQ-028 Macro TIM_PWM_PRELOAD_EN defined: arr_act/ccr_act are shadow registers reloaded from arr/ccr on IDLE->RUN and on every wrap edge; mid-period changes of arr/ccr do not affect the current period.
REQ-029 Macro not defined: arr_act=arr and ccr_act=ccr directly; changes act on the next tick; no shadow registers synthesised.

Structure
REQ-030 Package tim_pkg holds state enum tim_state_e (IDLE, RUN, DONE) and default parameter constants.
REQ-031 Sub-module tim_psc (PSC_W param) implements REQ-018/019, ports clk, rst, clr, run, psc, tick.

Verification
REQ-032 psc=0, arr=3, ccr[0]=2, en=1 -> cnt 0,1,2,3,0..., pwm[0] 1,1,0,0 repeating, upd every 4th cycle.
REQ-033 psc=2, arr=1 -> cnt changes every 3 clk; upd period 6 clk.
REQ-034 one_shot=1, psc=0, arr=2 -> one upd pulse, DONE, cnt=0, busy=0; en low then high restarts.
REQ-035 ccr={0,5,9,2}, arr=4 -> pwm[0]=0 constant, pwm[1]=1 constant, pwm[2]=1 constant, pwm[3] duty 2/5.
REQ-036 With TIM_PWM_PRELOAD_EN, arr 7->3 at cnt=2: cnt reaches 7 then period 4; without macro wraps at 3 immediately.
REQ-037 rst pulse asynchronous at cnt=5 -> all outputs 0 before next clk edge; RUN resumes from cnt=0.

Source files
------------

// File: rtl/tim_pkg.sv
// Shared types and default sizes for the PWM timer.
// Build option TIM_PWM_PRELOAD_EN selects shadowed arr/ccr.
package tim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tim_state_e;

  localparam int TIM_WIDTH_DEF = 16;
  localparam int TIM_PSC_W_DEF = 16;
  localparam int TIM_CH_DEF    = 4;

endpackage

// File: rtl/tim_psc.sv
// Clock prescaler: one tick per psc+1 cycles while run is high.
// Uses >= so a psc lowered mid-count ticks on the next cycle.
module tim_psc
  import tim_pkg::*;
#(
  parameter int PSC_W = TIM_PSC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] r_psc_cnt;

  assign tick = run && (r_psc_cnt >= psc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psc_cnt <= '0;
    end else if (clr || tick) begin
      r_psc_cnt <= '0;
    end else if (run) begin
      r_psc_cnt <= r_psc_cnt + PSC_W'(1);
    end
  end

endmodule

// File: rtl/tim_pwm.sv
// Up-counting PWM timer with prescaler, one-shot and CH compare outputs.
// Define TIM_PWM_PRELOAD_EN to shadow arr/ccr until the next wrap.
module tim_pwm
  import tim_pkg::*;
#(
  parameter int WIDTH = TIM_WIDTH_DEF,
  parameter int PSC_W = TIM_PSC_W_DEF,
  parameter int CH    = TIM_CH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      one_shot,
  input  logic [PSC_W-1:0]          psc,
  input  logic [WIDTH-1:0]          arr,
  input  logic [CH-1:0][WIDTH-1:0]  ccr,
  output logic [WIDTH-1:0]          cnt,
  output logic [CH-1:0]             pwm,
  output logic                      upd,
  output logic                      busy
);

  tim_state_e r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [CH-1:0] r_pwm;
  logic r_upd;
  logic r_busy;

  logic w_run;
  logic w_clr;
  logic w_tick;
  logic w_wrap;
  logic [WIDTH-1:0] w_arr_act;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [CH-1:0][WIDTH-1:0] w_ccr_nxt;
  logic [CH-1:0] w_pwm_nxt;

  assign w_run = en && (r_state == RUN);
  assign w_clr = !w_run;

  tim_psc #(
    .PSC_W(PSC_W)
  ) u_psc (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .run  (w_run),
    .psc  (psc),
    .tick (w_tick)
  );

  assign w_wrap = (r_cnt == w_arr_act);

`ifdef TIM_PWM_PRELOAD_EN
  logic [WIDTH-1:0] r_arr_sh;
  logic [CH-1:0][WIDTH-1:0] r_ccr_sh;
  logic w_load;

  assign w_load = (en && r_state == IDLE)
               || (w_tick && w_wrap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arr_sh <= '0;
      r_ccr_sh <= '0;
    end else if (w_load) begin
      r_arr_sh <= arr;
      r_ccr_sh <= ccr;
    end
  end

  assign w_arr_act = r_arr_sh;
  // Compare for the next cycle must see the value being loaded now.
  assign w_ccr_nxt = w_load ? ccr : r_ccr_sh;
`else
  assign w_arr_act = arr;
  assign w_ccr_nxt = ccr;
`endif

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_pwm_nxt = '0;
    if (r_state != RUN) begin
      w_cnt_nxt = '0;
    end else if (w_tick) begin
      w_cnt_nxt = w_wrap ? '0 : r_cnt + WIDTH'(1);
    end
    for (int i = 0; i < CH; i++) begin
      w_pwm_nxt[i] = (w_cnt_nxt < w_ccr_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pwm   <= '0;
      r_upd   <= 1'b0;
      r_busy  <= 1'b0;
    end else if (!en) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pwm   <= '0;
      r_upd   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= RUN;
          r_cnt   <= '0;
          r_pwm   <= w_pwm_nxt;
          r_upd   <= 1'b0;
          r_busy  <= 1'b1;
        end
        RUN: begin
          r_cnt <= w_cnt_nxt;
          r_upd <= w_tick && w_wrap;
          if (w_tick && w_wrap && one_shot) begin
            r_state <= DONE;
            r_pwm   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_pwm  <= w_pwm_nxt;
            r_busy <= 1'b1;
          end
        end
        DONE: begin
          r_cnt  <= '0;
          r_pwm  <= '0;
          r_upd  <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_pwm   <= '0;
          r_upd   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cnt  = r_cnt;
  assign pwm  = r_pwm;
  assign upd  = r_upd;
  assign busy = r_busy;

endmodule

// File: tb/tb_tim_pwm.sv
// Scoreboard bench for tim_pwm: expected outputs queued per edge.
// Honours TIM_PWM_PRELOAD_EN for the reload-timing scenario.
module tb_tim_pwm;

  typedef struct packed {
    logic [15:0] cnt;
    logic [3:0]  pwm;
    logic        upd;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic one_shot;
  logic [15:0] psc;
  logic [15:0] arr;
  logic [3:0][15:0] ccr;
  logic [15:0] cnt;
  logic [3:0] pwm;
  logic upd;
  logic busy;

  int errors = 0;
  int checks = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  tim_pwm dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .one_shot (one_shot),
    .psc      (psc),
    .arr      (arr),
    .ccr      (ccr),
    .cnt      (cnt),
    .pwm      (pwm),
    .upd      (upd),
    .busy     (busy)
  );

  // Closed form for a free-running timer, k edges after en rose.
  function automatic exp_t exp_per(int k, int p, int a,
                                   logic [3:0][15:0] c);
    exp_t e;
    int t;
    t = (k - 1) / (p + 1);
    e.cnt  = 16'(t % (a + 1));
    e.upd  = (k > 1) && ((k - 1) % (p + 1) == 0)
          && (t % (a + 1) == 0);
    e.busy = 1'b1;
    for (int i = 0; i < 4; i++) e.pwm[i] = (e.cnt < c[i]);
    return e;
  endfunction

  task automatic go_idle();
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_periodic(string nm, int p, int a,
                              logic [3:0][15:0] c, int n);
    exp_t e;
    psc = 16'(p);
    arr = 16'(a);
    ccr = c;
    en  = 1'b1;
    for (int k = 1; k <= n; k++) begin
      q.push_back(exp_per(k, p, a, c));
      @(posedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if ({cnt, pwm, upd, busy} !== e) begin
        errors++;
        $display("FAIL %s k=%0d got cnt=%0d pwm=%h upd=%b busy=%b exp cnt=%0d pwm=%h upd=%b busy=%b",
                 nm, k, cnt, pwm, upd, busy,
                 e.cnt, e.pwm, e.upd, e.busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    one_shot = 1'b0;
    psc = '0;
    arr = '0;
    ccr = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d exp=0", cnt);
    end
    checks++;
    if (pwm !== 4'd0) begin
      errors++;
      $display("FAIL reset_pwm got=%h exp=0", pwm);
    end
    checks++;
    if (upd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got upd=%b busy=%b exp 0 0",
               upd, busy);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL idle_hold got busy=%b cnt=%0d exp 0 0",
               busy, cnt);
    end
  endtask

  task automatic test_basic();
    run_periodic("basic", 0, 3, {16'd4, 16'd3, 16'd1, 16'd2}, 12);
    go_idle();
  endtask

  task automatic test_prescale();
    run_periodic("prescale", 2, 1, {16'd2, 16'd1, 16'd0, 16'd1}, 14);
    go_idle();
  endtask

  task automatic test_arr_zero();
    run_periodic("arr_zero", 1, 0, {16'd0, 16'd0, 16'd1, 16'd1}, 8);
    go_idle();
  endtask

  task automatic test_ccr_edges();
    int hi;
    run_periodic("ccr_edges", 0, 4, {16'd2, 16'd9, 16'd5, 16'd0}, 10);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      hi += int'(pwm[3]);
    end
    checks++;
    if (hi != 4) begin
      errors++;
      $display("FAIL ccr_duty got=%0d/10 exp=4/10", hi);
    end
    go_idle();
  endtask

  task automatic test_psc_change();
    exp_t e;
    int exp_cnt [8] = '{0, 0, 0, 0, 0, 1, 1, 2};
    psc = 16'd5;
    arr = 16'd7;
    ccr = {4{16'd1}};
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 6) psc = 16'd1;
      e.cnt  = 16'(exp_cnt[k-1]);
      e.pwm  = (exp_cnt[k-1] == 0) ? 4'hF : 4'h0;
      e.upd  = 1'b0;
      e.busy = 1'b1;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if ({cnt, pwm, upd, busy} !== e) begin
        errors++;
        $display("FAIL psc_change k=%0d got cnt=%0d pwm=%h upd=%b exp cnt=%0d pwm=%h upd=%b",
                 k, cnt, pwm, upd, e.cnt, e.pwm, e.upd);
      end
    end
    go_idle();
  endtask

  task automatic test_one_shot();
    exp_t e;
    exp_t tbl [9] = '{
      '{16'd0, 4'hF, 1'b0, 1'b1},
      '{16'd1, 4'h0, 1'b0, 1'b1},
      '{16'd2, 4'h0, 1'b0, 1'b1},
      '{16'd0, 4'h0, 1'b1, 1'b0},
      '{16'd0, 4'h0, 1'b0, 1'b0},
      '{16'd0, 4'h0, 1'b0, 1'b0},
      '{16'd0, 4'h0, 1'b0, 1'b0},
      '{16'd0, 4'hF, 1'b0, 1'b1},
      '{16'd1, 4'h0, 1'b0, 1'b1}
    };
    int ups;
    ups = 0;
    psc = 16'd0;
    arr = 16'd2;
    ccr = {4{16'd1}};
    one_shot = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      en = (k != 7);
      q.push_back(tbl[k-1]);
      @(posedge clk);
      #1;
      if (k <= 7) ups += int'(upd);
      e = q.pop_front();
      checks++;
      if ({cnt, pwm, upd, busy} !== e) begin
        errors++;
        $display("FAIL one_shot k=%0d got cnt=%0d pwm=%h upd=%b busy=%b exp cnt=%0d pwm=%h upd=%b busy=%b",
                 k, cnt, pwm, upd, busy,
                 e.cnt, e.pwm, e.upd, e.busy);
      end
    end
    checks++;
    if (ups != 1) begin
      errors++;
      $display("FAIL one_shot_pulses got=%0d exp=1", ups);
    end
    one_shot = 1'b0;
    go_idle();
  endtask

  task automatic test_arr_change();
    exp_t e;
`ifdef TIM_PWM_PRELOAD_EN
    int seq [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 0};
`else
    int seq [13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
`endif
    psc = 16'd0;
    arr = 16'd7;
    ccr = '0;
    en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      if (k == 4) arr = 16'd3;
      e.cnt  = 16'(seq[k-1]);
      e.pwm  = 4'h0;
      e.upd  = (k > 1) && (seq[k-1] == 0);
      e.busy = 1'b1;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if ({cnt, pwm, upd, busy} !== e) begin
        errors++;
        $display("FAIL arr_change k=%0d got cnt=%0d upd=%b exp cnt=%0d upd=%b",
                 k, cnt, upd, e.cnt, e.upd);
      end
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    logic [3:0][15:0] c;
    c = {4{16'd3}};
    run_periodic("pre_rst", 0, 7, c, 6);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cnt !== 16'd0 || pwm !== 4'd0) begin
      errors++;
      $display("FAIL async_rst_data got cnt=%0d pwm=%h exp 0 0",
               cnt, pwm);
    end
    checks++;
    if (upd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_flags got upd=%b busy=%b exp 0 0",
               upd, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_periodic("post_rst", 0, 7, c, 10);
    go_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_arr_zero();
    test_ccr_edges();
    test_psc_change();
    test_one_shot();
    test_arr_change();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
